// File: rtl/vga_timing_gen_if.sv
// Raster/pixel bus between the VGA timing generator and the pixel-colour logic.
// The master side owns the counters and pins; the slave side returns colour.
interface vga_timing_gen_if;
    logic [3:0]  r_in;
    logic [3:0]  g_in;
    logic [3:0]  b_in;
    logic [10:0] draw_x;
    logic [10:0] draw_y;
    logic        active;
    logic        frame_tick;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        input  r_in, g_in, b_in,
        output draw_x, draw_y, active, frame_tick,
        output hsync, vsync, vga_r, vga_g, vga_b
    );

    modport slave (
        output r_in, g_in, b_in,
        input  draw_x, draw_y, active, frame_tick,
        input  hsync, vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters, sync generation and colour blanking for a VGA output; sync and
// blanking are delayed to match the pixel logic's read latency so pins stay aligned.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 64,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 200,
    parameter int unsigned V_ACTIVE = 800,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 24,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b1,
    parameter int unsigned PIPE_DLY = 1
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_W   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_W   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_TICK_Y  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END    = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END    = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{act: 1'b0, hs: ~H_POL, vs: ~V_POL};

    // Reject geometries the 11-bit counters or the delay line cannot represent.
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen: totals exceed 11-bit counter range");
    end
    if (PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end

    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_frame_tick;
    logic          r_hsync;
    logic          r_vsync;
    logic [3:0]    r_vga_r;
    logic [3:0]    r_vga_g;
    logic [3:0]    r_vga_b;

    logic          w_x_wrap;
    logic          w_y_wrap;
    logic          w_active;
    logic          w_hs_raw;
    logic          w_vs_raw;
    ctl_t          w_ctl_raw;
    ctl_t          w_ctl_d;

    assign w_x_wrap = (r_x == H_MAX);
    assign w_y_wrap = (r_y == V_MAX);

    // Raster counters: x every clock, y on each line wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_wrap) begin
            r_x <= '0;
            r_y <= w_y_wrap ? '0 : r_y + CW'(1);
        end else begin
            r_x <= r_x + CW'(1);
        end
    end

    // Undelayed raster decode; vs_raw only moves with r_y, so it is line-aligned.
    always_comb begin
        w_active  = (r_x < H_ACT_W) && (r_y < V_ACT_W);
        w_hs_raw  = ((r_x >= HS_START) && (r_x < HS_END)) ? H_POL : ~H_POL;
        w_vs_raw  = ((r_y >= VS_START) && (r_y < VS_END)) ? V_POL : ~V_POL;
        w_ctl_raw = '{act: w_active, hs: w_hs_raw, vs: w_vs_raw};
    end

    // Registered so the pulse is seen while the counters read (0, V_ACTIVE).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_x_wrap && (r_y == V_TICK_Y);
        end
    end

    // Delay line matching the pixel logic's read latency.
    if (PIPE_DLY == 0) begin : g_nodly
        assign w_ctl_d = w_ctl_raw;
    end else begin : g_dly
        for (genvar s = 0; s < PIPE_DLY; s++) begin : g_stage
            ctl_t r_q;
            ctl_t w_prev;

            if (s == 0) begin : g_first
                assign w_prev = w_ctl_raw;
            end else begin : g_next
                assign w_prev = g_stage[s-1].r_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q <= CTL_IDLE;
                end else begin
                    r_q <= w_prev;
                end
            end
        end
        assign w_ctl_d = g_stage[PIPE_DLY-1].r_q;
    end

    // Pin register: colour is sampled together with its delayed blanking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_vga_r <= 4'h0;
            r_vga_g <= 4'h0;
            r_vga_b <= 4'h0;
        end else begin
            r_hsync <= w_ctl_d.hs;
            r_vsync <= w_ctl_d.vs;
            r_vga_r <= w_ctl_d.act ? vga.r_in : 4'h0;
            r_vga_g <= w_ctl_d.act ? vga.g_in : 4'h0;
            r_vga_b <= w_ctl_d.act ? vga.b_in : 4'h0;
        end
    end

    assign vga.draw_x     = r_x;
    assign vga.draw_y     = r_y;
    assign vga.active     = w_active;
    assign vga.frame_tick = r_frame_tick;
    assign vga.hsync      = r_hsync;
    assign vga.vsync      = r_vsync;
    assign vga.vga_r      = r_vga_r;
    assign vga.vga_g      = r_vga_g;
    assign vga.vga_b      = r_vga_b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance for whole-frame behaviour
// and a default-geometry instance for the first line of real 1280x800 timing.
module tb_vga_timing_gen;

    localparam int SHT = 25;   // 16 + 2 + 3 + 4
    localparam int SVT = 11;   // 6 + 1 + 2 + 2
    localparam int SFR = SHT * SVT;
    localparam int FHT = 1680;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if s_if ();
    vga_timing_gen_if f_if ();

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b0),  .V_POL(1'b1), .PIPE_DLY(1)
    ) u_small (
        .clk(clk),
        .rst(rst),
        .vga(s_if)
    );

    vga_timing_gen u_full (
        .clk(clk),
        .rst(rst),
        .vga(f_if)
    );

    typedef struct {
        int         cyc;
        logic [10:0] x;
        logic [10:0] y;
        logic       act;
        logic       tick;
        logic       hs;
        logic       vs;
        logic [3:0] r;
        logic [3:0] g;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Emulated ROM: colour for the coordinate shown one clock earlier.
    task automatic drive(input int c);
        s_if.r_in = (c >= 1) ? 4'((c - 1) % SHT) : 4'h0;
        s_if.g_in = 4'hA;
        s_if.b_in = 4'h5;
        f_if.r_in = 4'hF;
        f_if.g_in = 4'hA;
        f_if.b_in = 4'h5;
    endtask

    // Expected small-instance state c clocks after reset release.
    task automatic check_small(input int c);
        int x, y, p, px, py;
        logic ea, et, pa, ehs, evs;
        logic [3:0] er, eg, eb;
        x  = c % SHT;
        y  = (c / SHT) % SVT;
        ea = (x < 16) && (y < 6);
        et = ((c % SFR) == 150);
        if (c < 2) begin
            ehs = 1'b1; evs = 1'b0; er = 4'h0; eg = 4'h0; eb = 4'h0;
        end else begin
            p   = c - 2;
            px  = p % SHT;
            py  = (p / SHT) % SVT;
            pa  = (px < 16) && (py < 6);
            ehs = !((px >= 18) && (px < 21));
            evs = (py >= 7) && (py < 9);
            er  = pa ? 4'(px) : 4'h0;
            eg  = pa ? 4'hA : 4'h0;
            eb  = pa ? 4'h5 : 4'h0;
        end
        chk($sformatf("s_x@%0d", c),    32'(s_if.draw_x),     32'(x));
        chk($sformatf("s_y@%0d", c),    32'(s_if.draw_y),     32'(y));
        chk($sformatf("s_act@%0d", c),  32'(s_if.active),     32'(ea));
        chk($sformatf("s_tick@%0d", c), 32'(s_if.frame_tick), 32'(et));
        chk($sformatf("s_hs@%0d", c),   32'(s_if.hsync),      32'(ehs));
        chk($sformatf("s_vs@%0d", c),   32'(s_if.vsync),      32'(evs));
        chk($sformatf("s_r@%0d", c),    32'(s_if.vga_r),      32'(er));
        chk($sformatf("s_g@%0d", c),    32'(s_if.vga_g),      32'(eg));
        chk($sformatf("s_b@%0d", c),    32'(s_if.vga_b),      32'(eb));
    endtask

    // Expected full-geometry state on the first lines after reset release.
    task automatic check_full(input int c);
        int px;
        logic pa, ehs;
        logic [3:0] er;
        if (c < 2) begin
            ehs = 1'b1; pa = 1'b0;
        end else begin
            px  = (c - 2) % FHT;
            pa  = (px < 1280);
            ehs = !((px >= 1344) && (px < 1480));
        end
        er = pa ? 4'hF : 4'h0;
        chk($sformatf("f_x@%0d", c),    32'(f_if.draw_x),     32'(c % FHT));
        chk($sformatf("f_y@%0d", c),    32'(f_if.draw_y),     32'(c / FHT));
        chk($sformatf("f_act@%0d", c),  32'(f_if.active),     32'((c % FHT) < 1280));
        chk($sformatf("f_tick@%0d", c), 32'(f_if.frame_tick), 32'd0);
        chk($sformatf("f_hs@%0d", c),   32'(f_if.hsync),      32'(ehs));
        chk($sformatf("f_vs@%0d", c),   32'(f_if.vsync),      32'd0);
        chk($sformatf("f_r@%0d", c),    32'(f_if.vga_r),      32'(er));
        chk($sformatf("f_g@%0d", c),    32'(f_if.vga_g),      32'(pa ? 4'hA : 4'h0));
        chk($sformatf("f_b@%0d", c),    32'(f_if.vga_b),      32'(pa ? 4'h5 : 4'h0));
    endtask

    task automatic check_tbl(input int c);
        foreach (tbl[i]) begin
            if (tbl[i].cyc == c) begin
                chk($sformatf("vec%0d_x", c),    32'(s_if.draw_x),     32'(tbl[i].x));
                chk($sformatf("vec%0d_y", c),    32'(s_if.draw_y),     32'(tbl[i].y));
                chk($sformatf("vec%0d_act", c),  32'(s_if.active),     32'(tbl[i].act));
                chk($sformatf("vec%0d_tick", c), 32'(s_if.frame_tick), 32'(tbl[i].tick));
                chk($sformatf("vec%0d_hs", c),   32'(s_if.hsync),      32'(tbl[i].hs));
                chk($sformatf("vec%0d_vs", c),   32'(s_if.vsync),      32'(tbl[i].vs));
                chk($sformatf("vec%0d_r", c),    32'(s_if.vga_r),      32'(tbl[i].r));
                chk($sformatf("vec%0d_g", c),    32'(s_if.vga_g),      32'(tbl[i].g));
            end
        end
    endtask

    // Free-run n clocks from a reset release, checking every sample.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            check_small(c);
            check_tbl(c);
            if (c < FHT + 20) check_full(c);
            drive(c);
            step();
        end
    endtask

    initial begin
        int  c;
        bit  found;

        //             cyc   x   y  act tick hs vs  r     g
        tbl.push_back('{  0,  0,  0, 1, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{  1,  1,  0, 1, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{  2,  2,  0, 1, 0, 1, 0, 4'h0, 4'hA});
        tbl.push_back('{ 17, 17,  0, 0, 0, 1, 0, 4'hF, 4'hA});
        tbl.push_back('{ 18, 18,  0, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{ 20, 20,  0, 0, 0, 0, 0, 4'h0, 4'h0});
        tbl.push_back('{ 22, 22,  0, 0, 0, 0, 0, 4'h0, 4'h0});
        tbl.push_back('{ 23, 23,  0, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{ 25,  0,  1, 1, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{ 27,  2,  1, 1, 0, 1, 0, 4'h0, 4'hA});
        tbl.push_back('{ 60, 10,  2, 1, 0, 1, 0, 4'h8, 4'hA});
        tbl.push_back('{150,  0,  6, 0, 1, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{151,  1,  6, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{176,  1,  7, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{177,  2,  7, 0, 0, 1, 1, 4'h0, 4'h0});
        tbl.push_back('{226,  1,  9, 0, 0, 1, 1, 4'h0, 4'h0});
        tbl.push_back('{227,  2,  9, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{274, 24, 10, 0, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{275,  0,  0, 1, 0, 1, 0, 4'h0, 4'h0});
        tbl.push_back('{277,  2,  0, 1, 0, 1, 0, 4'h0, 4'hA});
        tbl.push_back('{425,  0,  6, 0, 1, 1, 0, 4'h0, 4'h0});

        // Held reset: counters parked, pins idle, no tick.
        rst = 1'b1;
        drive(0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rst_x#%0d", i),    32'(s_if.draw_x),     32'd0);
            chk($sformatf("rst_tick#%0d", i), 32'(s_if.frame_tick), 32'd0);
            chk($sformatf("rst_hs#%0d", i),   32'(s_if.hsync),      32'd1);
            chk($sformatf("rst_vs#%0d", i),   32'(s_if.vsync),      32'd0);
            chk($sformatf("rst_r#%0d", i),    32'(s_if.vga_r),      32'd0);
            chk($sformatf("rst_fy#%0d", i),   32'(f_if.draw_y),     32'd0);
        end
        rst = 1'b0;
        run(1700);

        // Walk on to the scaled mid-frame point, then pulse reset for one clock.
        c = 1700;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (s_if.draw_x == 11'd10 && s_if.draw_y == 11'd4) begin
                found = 1'b1;
                break;
            end
            drive(c);
            step();
            c++;
        end
        chk("reach_mid_frame", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(440);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
